// File: rtl/spi_slave_pkg.sv
// Shared constants, state type and phase-length helper for the SPI register bridge.
package spi_slave_pkg;

  localparam logic [7:0] CMD_WRITE = 8'h00;
  localparam logic [7:0] CMD_READ  = 8'h01;

  localparam int unsigned INSTR_BITS  = 8;
  localparam int unsigned GAP_BITS    = 1;
  localparam int unsigned ADDR_BITS   = 32;
  localparam int unsigned DATA_BITS   = 32;
  localparam int unsigned DUMMY_BITS  = 8;
  localparam int unsigned STATUS_BITS = 8;

  // Bit positions inside the status byte; [7:4] carry the block ID.
  localparam int unsigned STAT_ERR_BIT = 0;
  localparam int unsigned STAT_TMO_BIT = 1;
  localparam int unsigned STAT_RD_BIT  = 2;

  typedef enum logic [3:0] {
    StIdle,
    StInstr,
    StGap,
    StAddr,
    StWdata,
    StWdummy,
    StRdummy,
    StRdata,
    StStatus,
    StIgnore
  } spi_state_e;

  // Bit-counter value at the sample event that completes the given phase.
  function automatic logic [5:0] phase_last(input spi_state_e st);
    case (st)
      StInstr:  phase_last = 6'(INSTR_BITS - 1);
      StGap:    phase_last = 6'(GAP_BITS - 1);
      StAddr:   phase_last = 6'(ADDR_BITS - 1);
      StWdata:  phase_last = 6'(DATA_BITS - 1);
      StRdata:  phase_last = 6'(DATA_BITS - 1);
      StWdummy: phase_last = 6'(DUMMY_BITS - 1);
      StRdummy: phase_last = 6'(DUMMY_BITS - 1);
      StStatus: phase_last = 6'(STATUS_BITS - 1);
      default:  phase_last = 6'd0;
    endcase
  endfunction

endpackage

// File: rtl/spi_sync_edge.sv
// Multi-stage synchroniser with single-cycle rise/fall pulses on the synchronised level.
module spi_sync_edge #(
  parameter int unsigned Stages   = 2,
  parameter logic        ResetVal = 1'b0
) (
  input  logic clk_i,
  input  logic rst_ni,
  input  logic d_i,
  output logic rise_o,
  output logic fall_o
);

  logic [Stages-1:0] sync_q, sync_d;
  logic              prev_q, prev_d;

  // Shift the raw input through the chain; remember last synchronised level.
  always_comb begin
    sync_d = (sync_q << 1) | Stages'(d_i);
    prev_d = sync_q[Stages-1];
  end

  // Chain and edge-history flops.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      sync_q <= {Stages{ResetVal}};
      prev_q <= ResetVal;
    end else begin
      sync_q <= sync_d;
      prev_q <= prev_d;
    end
  end

  assign rise_o = sync_q[Stages-1] & ~prev_q;
  assign fall_o = ~sync_q[Stages-1] & prev_q;

endmodule

// File: rtl/spi_slave_bridge.sv
// SPI mode-0 target decoding 32-bit register frames into single-beat register-bus requests.
module spi_slave_bridge
  import spi_slave_pkg::*;
#(
  parameter int unsigned SYNC_STAGES = 2,
  parameter int unsigned BUS_TIMEOUT = 16,
  parameter logic [3:0]  STATUS_ID   = 4'hA
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        sck,
  input  logic        ss_n,
  input  logic        mosi,
  output logic        miso,
  output logic        bus_req,
  output logic        bus_we,
  output logic [31:0] bus_addr,
  output logic [31:0] bus_wdata,
  input  logic        bus_ack,
  input  logic        bus_err,
  input  logic [31:0] bus_rdata
);

  localparam int unsigned TmoW = $clog2(BUS_TIMEOUT + 1);

  logic                   sck_rise, sck_fall;
  logic [SYNC_STAGES-1:0] ss_sync_q, ss_sync_d, mosi_sync_q, mosi_sync_d;
  logic                   ss_s, mosi_s;

  spi_sync_edge #(
    .Stages   (SYNC_STAGES),
    .ResetVal (1'b0)
  ) u_sck_sync (
    .clk_i  (clk),
    .rst_ni (rst_n),
    .d_i    (sck),
    .rise_o (sck_rise),
    .fall_o (sck_fall)
  );

  spi_state_e       state_q, state_d;
  logic [5:0]       cnt_q, cnt_d;
  logic [31:0]      sr_q, sr_d, out_q, out_d, addr_q, addr_d, wdata_q, wdata_d;
  logic [TmoW-1:0]  tmo_cnt_q, tmo_cnt_d;
  logic             miso_q, miso_d, req_q, req_d, we_q, we_d;
  logic             is_read_q, is_read_d, owned_q, owned_d, timeout_q, timeout_d;
  logic             err_q, err_d, armed_q, armed_d;

  logic        sample, shift, last, ack_take, expire, pending, err_eff, tmo_eff;
  logic [31:0] sr_next, out_cur;
  logic [7:0]  status;

  assign ss_s   = ss_sync_q[SYNC_STAGES-1];
  assign mosi_s = mosi_sync_q[SYNC_STAGES-1];

  // Plain synchronisers for select and data; same depth as sck keeps mosi aligned to its edges.
  always_comb begin
    ss_sync_d   = (ss_sync_q << 1) | SYNC_STAGES'(ss_n);
    mosi_sync_d = (mosi_sync_q << 1) | SYNC_STAGES'(mosi);
  end

  // Event qualification and bus-result bookkeeping shared by the FSM.
  always_comb begin
    sample   = sck_rise & ~ss_s;
    shift    = sck_fall & ~ss_s;
    last     = (cnt_q == phase_last(state_q));
    sr_next  = {sr_q[30:0], mosi_s};
    ack_take = req_q & bus_ack & owned_q;
    // Ack in the expiry cycle wins, so expiry requires no ack.
    expire   = req_q & ~bus_ack & (tmo_cnt_q == TmoW'(BUS_TIMEOUT - 1));
    // Result still owed to this frame and not arriving this cycle.
    pending  = req_q & owned_q & ~bus_ack;
    err_eff  = ack_take ? bus_err : err_q;
    tmo_eff  = timeout_q | pending;
    out_cur  = (ack_take & is_read_q) ? bus_rdata : out_q;
  end

  // Status byte as it would be sent if loaded this cycle.
  always_comb begin
    status               = '0;
    status[7:4]          = STATUS_ID;
    status[STAT_RD_BIT]  = is_read_q;
    status[STAT_TMO_BIT] = tmo_eff;
    status[STAT_ERR_BIT] = err_eff;
  end

  // Next-state logic: bus handshake, then frame FSM, then miso gating.
  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    sr_d      = sr_q;
    out_d     = out_cur;
    addr_d    = addr_q;
    wdata_d   = wdata_q;
    tmo_cnt_d = tmo_cnt_q;
    miso_d    = miso_q;
    req_d     = req_q;
    we_d      = we_q;
    is_read_d = is_read_q;
    owned_d   = owned_q;
    timeout_d = timeout_q;
    err_d     = err_q;
    armed_d   = armed_q;

    if (req_q) begin
      tmo_cnt_d = tmo_cnt_q + 1'b1;
      if (bus_ack || expire) begin
        req_d     = 1'b0;
        tmo_cnt_d = '0;
        owned_d   = 1'b0;
      end
      if (ack_take) err_d = bus_err;
      if (expire && owned_q) timeout_d = 1'b1;
    end

    if (state_q == StIdle) begin
      if (ss_s) begin
        armed_d = 1'b1;
      end else if (armed_q && !req_q) begin
        state_d   = StInstr;
        cnt_d     = '0;
        armed_d   = 1'b0;
        is_read_d = 1'b0;
        timeout_d = 1'b0;
        err_d     = 1'b0;
        out_d     = '0;
      end
    end else if (ss_s) begin
      // Abandon the frame; any outstanding request finishes unobserved.
      state_d = StIdle;
      owned_d = 1'b0;
    end else begin
      if (shift) begin
        miso_d = 1'b0;
        if ((state_q == StRdata || state_q == StStatus) && cnt_q == 6'd0 && pending) begin
          // Too late for this frame: report timeout and ignore the eventual ack.
          timeout_d = 1'b1;
          owned_d   = 1'b0;
        end
        if (state_q == StStatus && cnt_q == 6'd0) begin
          miso_d = status[7];
          out_d  = {status[6:0], 25'd0};
        end else if (state_q == StRdata || state_q == StStatus) begin
          miso_d = out_cur[31];
          out_d  = {out_cur[30:0], 1'b0};
        end
      end

      if (sample) begin
        cnt_d = cnt_q + 6'd1;
        if (state_q == StInstr || state_q == StGap || state_q == StAddr || state_q == StWdata) begin
          sr_d = sr_next;
        end
        if (last) begin
          cnt_d = '0;
          case (state_q)
            StInstr: begin
              is_read_d = (sr_next[7:0] == CMD_READ);
              state_d   = (sr_next[7:0] == CMD_READ || sr_next[7:0] == CMD_WRITE) ?
                          StGap : StIgnore;
            end
            StGap: state_d = StAddr;
            StAddr: begin
              addr_d = sr_next;
              if (is_read_q) begin
                req_d     = 1'b1;
                we_d      = 1'b0;
                owned_d   = 1'b1;
                tmo_cnt_d = '0;
                out_d     = '0;
                state_d   = StRdummy;
              end else begin
                state_d = StWdata;
              end
            end
            StWdata: begin
              wdata_d   = sr_next;
              req_d     = 1'b1;
              we_d      = 1'b1;
              owned_d   = 1'b1;
              tmo_cnt_d = '0;
              state_d   = StWdummy;
            end
            StWdummy: state_d = StStatus;
            StRdummy: state_d = StRdata;
            StRdata:  state_d = StStatus;
            StStatus: state_d = StIgnore;
            default:  state_d = state_q;
          endcase
        end
      end
    end

    if (!(state_d == StRdata || state_d == StStatus)) miso_d = 1'b0;
  end

  // State registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ss_sync_q   <= '1;
      mosi_sync_q <= '0;
      state_q     <= StIdle;
      cnt_q       <= '0;
      sr_q        <= '0;
      out_q       <= '0;
      addr_q      <= '0;
      wdata_q     <= '0;
      tmo_cnt_q   <= '0;
      miso_q      <= 1'b0;
      req_q       <= 1'b0;
      we_q        <= 1'b0;
      is_read_q   <= 1'b0;
      owned_q     <= 1'b0;
      timeout_q   <= 1'b0;
      err_q       <= 1'b0;
      armed_q     <= 1'b0;
    end else begin
      ss_sync_q   <= ss_sync_d;
      mosi_sync_q <= mosi_sync_d;
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      sr_q        <= sr_d;
      out_q       <= out_d;
      addr_q      <= addr_d;
      wdata_q     <= wdata_d;
      tmo_cnt_q   <= tmo_cnt_d;
      miso_q      <= miso_d;
      req_q       <= req_d;
      we_q        <= we_d;
      is_read_q   <= is_read_d;
      owned_q     <= owned_d;
      timeout_q   <= timeout_d;
      err_q       <= err_d;
      armed_q     <= armed_d;
    end
  end

  assign miso      = miso_q;
  assign bus_req   = req_q;
  assign bus_we    = we_q;
  assign bus_addr  = addr_q;
  assign bus_wdata = wdata_q;

endmodule

// File: tb/tb_spi_slave_bridge.sv
// Directed bench for spi_slave_bridge with bus and miso scoreboards.
module tb_spi_slave_bridge;
  import spi_slave_pkg::*;

  logic        clk = 1'b0;
  logic        rst_n, sck, ss_n, mosi, miso;
  logic        bus_req, bus_we, bus_ack, bus_err;
  logic [31:0] bus_addr, bus_wdata, bus_rdata;

  typedef struct packed {
    logic        we;
    logic [31:0] addr;
    logic [31:0] wdata;
  } bus_txn_t;

  bus_txn_t    bus_sb[$];
  logic [39:0] miso_sb[$];
  int          total = 0;
  int          bad = 0;
  int          ack_delay = 0;
  logic [31:0] rsp_rdata = '0;
  logic        rsp_err = 1'b0;
  int          req_len = 0;

  always #5 clk = ~clk;

  spi_slave_bridge dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .sck       (sck),
    .ss_n      (ss_n),
    .mosi      (mosi),
    .miso      (miso),
    .bus_req   (bus_req),
    .bus_we    (bus_we),
    .bus_addr  (bus_addr),
    .bus_wdata (bus_wdata),
    .bus_ack   (bus_ack),
    .bus_err   (bus_err),
    .bus_rdata (bus_rdata)
  );

  task automatic check(input string tag, input logic [71:0] obs, input logic [71:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Bus responder: ack ack_delay cycles after bus_req rises (0 = never).
  initial begin
    int   cnt;
    logic acked;
    cnt = 0;
    acked = 1'b0;
    bus_ack = 1'b0;
    bus_err = 1'b0;
    bus_rdata = '0;
    forever begin
      @(posedge clk);
      #1;
      bus_ack = 1'b0;
      if (bus_req && !acked) begin
        cnt++;
        if (ack_delay != 0 && cnt == ack_delay) begin
          bus_ack = 1'b1;
          bus_err = rsp_err;
          bus_rdata = rsp_rdata;
          acked = 1'b1;
        end
      end else if (!bus_req) begin
        cnt = 0;
        acked = 1'b0;
      end
    end
  end

  // Bus monitor: pop expected request on each bus_req rise, record request length.
  initial begin
    logic     req_prev;
    int       len;
    bus_txn_t e;
    req_prev = 1'b0;
    len = 0;
    forever begin
      @(negedge clk);
      if (bus_req && !req_prev) begin
        total++;
        assert (bus_sb.size() > 0) else begin
          bad++;
          $error("FAIL unexpected_bus_req observed=req expected=none addr=%0h", bus_addr);
        end
        if (bus_sb.size() > 0) begin
          e = bus_sb.pop_front();
          check("bus_we", 72'(bus_we), 72'(e.we));
          check("bus_addr", 72'(bus_addr), 72'(e.addr));
          if (e.we) check("bus_wdata", 72'(bus_wdata), 72'(e.wdata));
        end
      end
      if (bus_req) len++;
      if (!bus_req && req_prev) begin
        req_len = len;
        len = 0;
      end
      req_prev = bus_req;
    end
  end

  task automatic spi_frame(input logic [7:0] ins, input logic [31:0] addr, input logic [31:0] wd,
                           input int nbits, output logic [88:0] rx);
    logic [88:0] tx;
    tx = {ins, 1'b0, addr, wd, 16'h0000};
    rx = '0;
    ss_n = 1'b0;
    #100;
    for (int i = 0; i < nbits; i++) begin
      mosi = tx[88-i];
      #80 sck = 1'b1;
      rx = {rx[87:0], miso};
      #80 sck = 1'b0;
    end
    #100 ss_n = 1'b1;
    mosi = 1'b0;
    #200;
  endtask

  task automatic wait_req_idle(input string name);
    for (int i = 0; i < 200 && bus_req; i++) @(negedge clk);
    check({name, "_req_dropped"}, 72'(bus_req), 72'(0));
  endtask

  task automatic run(input string name, input logic [7:0] ins, input logic [31:0] addr,
                     input logic [31:0] wd, input int delay, input logic [31:0] rdata,
                     input logic err, input bit exp_bus, input logic [31:0] exp_data,
                     input logic [7:0] exp_stat);
    logic [88:0] rx;
    logic [39:0] exp;
    ack_delay = delay;
    rsp_rdata = rdata;
    rsp_err = err;
    if (exp_bus) bus_sb.push_back({(ins == CMD_WRITE), addr, wd});
    miso_sb.push_back({exp_data, exp_stat});
    spi_frame(ins, addr, wd, 89, rx);
    wait_req_idle(name);
    exp = miso_sb.pop_front();
    check({name, "_miso_quiet"}, 72'(rx[88:40]), 72'(0));
    check({name, "_data"}, 72'(rx[39:8]), 72'(exp[39:8]));
    check({name, "_status"}, 72'(rx[7:0]), 72'(exp[7:0]));
    check({name, "_bus_sb_empty"}, 72'(bus_sb.size()), 72'(0));
  endtask

  task automatic check_reset_outputs(input string name);
    check({name, "_miso"}, 72'(miso), 72'(0));
    check({name, "_bus_req"}, 72'(bus_req), 72'(0));
    check({name, "_bus_we"}, 72'(bus_we), 72'(0));
    check({name, "_bus_addr"}, 72'(bus_addr), 72'(0));
    check({name, "_bus_wdata"}, 72'(bus_wdata), 72'(0));
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    logic [88:0] rx;
    rst_n = 1'b0;
    sck = 1'b0;
    ss_n = 1'b1;
    mosi = 1'b0;
    #30;
    check_reset_outputs("reset");
    rst_n = 1'b1;
    #50;

    run("wr_clean", CMD_WRITE, 32'h0000_0010, 32'hDEAD_BEEF, 3, '0, 1'b0, 1'b1, '0, 8'hA0);
    run("rd_clean", CMD_READ, 32'h0000_0020, '0, 2, 32'h1234_5678, 1'b0, 1'b1,
        32'h1234_5678, 8'hA4);

    req_len = 0;
    run("rd_timeout", CMD_READ, 32'h0000_0030, '0, 0, 32'hFFFF_FFFF, 1'b0, 1'b1, '0, 8'hA6);
    check("rd_timeout_req_len", 72'(req_len), 72'(16));

    run("wr_err", CMD_WRITE, 32'h0000_0040, 32'h0BAD_F00D, 4, '0, 1'b1, 1'b1, '0, 8'hA1);

    // Ack landing on the last allowed cycle still counts; one cycle later is a timeout.
    run("wr_ack_edge", CMD_WRITE, 32'h0000_0050, 32'h1111_2222, 16, '0, 1'b0, 1'b1, '0, 8'hA0);
    req_len = 0;
    run("wr_ack_late", CMD_WRITE, 32'h0000_0060, 32'h3333_4444, 17, '0, 1'b0, 1'b1, '0, 8'hA2);
    check("wr_ack_late_req_len", 72'(req_len), 72'(16));

    run("bad_instr", 8'h05, 32'h0000_0070, 32'hFFFF_FFFF, 1, 32'hFFFF_FFFF, 1'b0, 1'b0,
        '0, 8'h00);
    run("rd_after_bad", CMD_READ, 32'h0000_0044, '0, 1, 32'hCAFE_F00D, 1'b0, 1'b1,
        32'hCAFE_F00D, 8'hA4);

    // Abort after 12 address bits: no request, miso silent.
    spi_frame(CMD_READ, 32'hABCD_0000, '0, 21, rx);
    check("abort_miso_quiet", 72'(rx), 72'(0));
    wait_req_idle("abort");

    // Reset pulsed in the middle of an instruction byte.
    ss_n = 1'b0;
    #100;
    for (int i = 0; i < 4; i++) begin
      mosi = i[0];
      #80 sck = 1'b1;
      #80 sck = 1'b0;
    end
    #80 sck = 1'b1;
    #40 rst_n = 1'b0;
    #20;
    check_reset_outputs("midframe_rst");
    sck = 1'b0;
    ss_n = 1'b1;
    mosi = 1'b0;
    #40 rst_n = 1'b1;
    #200;

    run("wr_after_rst", CMD_WRITE, 32'h0000_0100, 32'h55AA_00FF, 2, '0, 1'b0, 1'b1, '0, 8'hA0);

    check("miso_sb_empty", 72'(miso_sb.size()), 72'(0));
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
